register_file_mp: RTL

Parametrised multi-port register file for the single-cycle/pipelined datapath: N combinational read ports, two write ports with fixed priority, optional write-to-read bypass, optional hardwired zero register and a per-register busy scoreboard for in-flight producers. Sits between decode (reads, reservations) and writeback (writes). It replaces the fixed 32x32, 2-read/1-write file, adding reset clearing, a second write port and hazard tracking.

---
 rtl/register_file_mp_if.sv | 30 +++
 rtl/register_file_mp.sv | 85 ++++++++
 2 files changed

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read ports, two write ports, reservation
// and collision flag. The master side sits in decode/writeback; the slave side is the file.
interface register_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int N_RD   = 2
);
  logic [N_RD*ADDR_W-1:0] rd_addr;
  logic [N_RD*DATA_W-1:0] rd_data;
  logic [N_RD-1:0]        rd_busy;
  logic                   we0;
  logic [ADDR_W-1:0]      wa0;
  logic [DATA_W-1:0]      wd0;
  logic                   we1;
  logic [ADDR_W-1:0]      wa1;
  logic [DATA_W-1:0]      wd1;
  logic                   rsv_en;
  logic [ADDR_W-1:0]      rsv_addr;
  logic                   wr_collide;

  modport master (
    output rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
    input  rd_data, rd_busy, wr_collide
  );

  modport slave (
    input  rd_addr, we0, wa0, wd0, we1, wa1, wd1, rsv_en, rsv_addr,
    output rd_data, rd_busy, wr_collide
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: N combinational reads, two prioritised writes,
// optional bypass and hardwired zero register, plus a per-register busy scoreboard.
module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic              clk,
  input logic              rst_n,
  register_file_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]      r_mem [DEPTH];
  logic [DEPTH-1:0]       r_busy;
  logic                   r_wr_collide;

  logic                   w_we0;
  logic                   w_we1;
  logic                   w_rsv;
  logic [DEPTH-1:0]       w_busy_nxt;
  logic [N_RD*DATA_W-1:0] w_rd_data;
  logic [N_RD-1:0]        w_rd_busy;

  // Writes and reservations aimed at the hardwired zero register are squashed here.
  assign w_we0 = bus.we0    && !(ZERO_REG != 0 && bus.wa0      == '0);
  assign w_we1 = bus.we1    && !(ZERO_REG != 0 && bus.wa1      == '0);
  assign w_rsv = bus.rsv_en && !(ZERO_REG != 0 && bus.rsv_addr == '0);

  // NOTE: every variable assigned in always_comb gets its default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_we0) w_busy_nxt[bus.wa0] = 1'b0;
    if (w_we1) w_busy_nxt[bus.wa1] = 1'b0;
    if (w_rsv) w_busy_nxt[bus.rsv_addr] = 1'b1;
  end

  // NOTE: the array is reset, so it must map to flops rather than a RAM macro;
  // clearing every entry on reset is part of the contract, not a convenience.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_busy       <= '0;
      r_wr_collide <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments; when both ports hit one address the
      // later statement (port 1) wins, which is exactly the required priority.
      if (w_we0) r_mem[bus.wa0] <= bus.wd0;
      if (w_we1) r_mem[bus.wa1] <= bus.wd1;
      r_busy       <= w_busy_nxt;
      r_wr_collide <= bus.we0 && bus.we1 && (bus.wa0 == bus.wa1);
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int p = 0; p < N_RD; p++) begin
      logic [ADDR_W-1:0] addr;
      addr = bus.rd_addr[p*ADDR_W +: ADDR_W];
      if (ZERO_REG != 0 && addr == '0) begin
        w_rd_data[p*DATA_W +: DATA_W] = '0;
        w_rd_busy[p]                  = 1'b0;
      end else if (BYPASS != 0 && rst_n) begin
        if (w_we1 && bus.wa1 == addr)
          w_rd_data[p*DATA_W +: DATA_W] = bus.wd1;
        else if (w_we0 && bus.wa0 == addr)
          w_rd_data[p*DATA_W +: DATA_W] = bus.wd0;
        else
          w_rd_data[p*DATA_W +: DATA_W] = r_mem[addr];
        w_rd_busy[p] = w_busy_nxt[addr];
      end else begin
        w_rd_data[p*DATA_W +: DATA_W] = r_mem[addr];
        w_rd_busy[p]                  = r_busy[addr];
      end
    end
  end

  assign bus.rd_data    = w_rd_data;
  assign bus.rd_busy    = w_rd_busy;
  assign bus.wr_collide = r_wr_collide;
endmodule
